div: RTL and testbench

- Multi-cycle 32-bit integer divider in the EX stage of the MIPS32 pipeline.
- Executes DIV/DIVU and produces the 64-bit {HI, LO} pair that writeback commits to the HI/LO register: HI = remainder, LO = quotient.
- Radix-2 restoring algorithm, one quotient bit per cycle.
- Talks to the EX stage and pipeline control through a start/ready/annul handshake; control stalls the pipeline while ready_o is low.

---
 rtl/div_pkg.sv | 32 +++
 rtl/div_if.sv | 39 +++
 rtl/div.sv | 171 +++++++++++++++++
 tb/tb_div.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the multi-cycle DIV/DIVU unit.
//   - div_state_e : FSM state encoding (2 bits), also driven out for debug
//   - handshake / reset level constants used by the divider and its users
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_DATA_W = 32;

  // Reset level.
  localparam logic RST_ENABLE = 1'b1;

  // start_i levels seen from the EX stage.
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  // ready_o levels.
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Width of the {HI, LO} result bus.
  localparam int DOUBLE_REG_BUS_W = 2 * DIV_DATA_W;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_if.sv
// -----------------------------------------------------------------------------
// div_if
// Request/result bundle between the EX stage (master) and the divider (slave).
//   signed_div_i : 1 = DIV, 0 = DIVU
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request, held high by the master until ready_o is seen
//   annul_i      : cancel the operation in flight; wins over start_i
//   result_o     : {remainder, quotient}, meaningful only while ready_o = 1
//   ready_o      : result valid
//
// Handshake: the master raises start_i with operands stable; the divider
// captures them on the first edge where start_i=1 and annul_i=0 in FREE.
// ready_o then rises once and result_o stays stable for as long as start_i
// remains high. Dropping start_i (or raising annul_i) retires the result on
// the next edge; a new request is only accepted from FREE, so at least one
// idle cycle separates two operations.
// -----------------------------------------------------------------------------
interface div_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div
// Multi-cycle radix-2 restoring divider for MIPS32 DIV/DIVU.
// Produces {HI, LO} = {remainder, quotient}; one quotient bit per cycle.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : div_if.slave (operands, start/annul, result/ready)
//   state_o : current FSM state, for debug/observation
//
// Timing: request accepted at edge T -> ready_o high after edge T+33
// (divide-by-zero: after edge T+2, result 0).
// -----------------------------------------------------------------------------
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_if.slave       bus,
  output div_state_e state_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  // Two's-complement negate.
  function automatic logic [DATA_W-1:0] neg2(input logic [DATA_W-1:0] v);
    return ~v + DATA_W'(1);
  endfunction

  div_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                signed_q;
  logic                dvd_neg_q;
  logic                dvs_neg_q;
  logic [DATA_W-1:0]   divisor_q;   // divisor magnitude
  logic [DATA_W-1:0]   rem_q;       // partial remainder
  logic [DATA_W-1:0]   quo_q;       // unshifted dividend bits / quotient bits
  logic [2*DATA_W-1:0] result_q;
  logic                ready_q;

  // Operand magnitudes at capture time. In signed mode 0x80000000 negates to
  // itself, which is exactly its magnitude when read as unsigned.
  logic [DATA_W-1:0] dvd_mag_d;
  logic [DATA_W-1:0] dvs_mag_d;

  always_comb begin
    dvd_mag_d = bus.opdata1_i;
    dvs_mag_d = bus.opdata2_i;
    if (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) dvd_mag_d = neg2(bus.opdata1_i);
    if (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) dvs_mag_d = neg2(bus.opdata2_i);
  end

  // One restoring step: bring the next dividend bit into the remainder and
  // try to subtract the divisor. The trial value is one bit wider than the
  // remainder; a set top bit of the difference means the subtract borrowed.
  logic [DATA_W:0]   trial_d;
  logic [DATA_W:0]   diff_d;
  logic              fits_d;
  logic [DATA_W-1:0] rem_step_d;
  logic [DATA_W-1:0] quo_step_d;

  always_comb begin
    trial_d    = {rem_q, quo_q[DATA_W-1]};
    diff_d     = trial_d - {1'b0, divisor_q};
    fits_d     = ~diff_d[DATA_W];
    rem_step_d = fits_d ? diff_d[DATA_W-1:0] : trial_d[DATA_W-1:0];
    quo_step_d = {quo_q[DATA_W-2:0], fits_d};
  end

  // Sign correction applied once the magnitude division is complete:
  // quotient is negative when the operand signs differ, remainder takes the
  // dividend's sign. -2^31 / -1 falls out as 0x80000000 with no special case.
  logic [DATA_W-1:0] quo_fix_d;
  logic [DATA_W-1:0] rem_fix_d;

  always_comb begin
    quo_fix_d = quo_q;
    rem_fix_d = rem_q;
    if (signed_q && (dvd_neg_q ^ dvs_neg_q)) quo_fix_d = neg2(quo_q);
    if (signed_q && dvd_neg_q)               rem_fix_d = neg2(rem_q);
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      signed_q  <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      case (state_q)
        DIV_FREE: begin
          ready_q  <= DIV_RESULT_NOT_READY;
          result_q <= '0;
          if (bus.start_i == DIV_START && !bus.annul_i) begin
            signed_q  <= bus.signed_div_i;
            dvd_neg_q <= bus.opdata1_i[DATA_W-1];
            dvs_neg_q <= bus.opdata2_i[DATA_W-1];
            divisor_q <= dvs_mag_d;
            rem_q     <= '0;
            quo_q     <= dvd_mag_d;
            cnt_q     <= '0;
            if (bus.opdata2_i == '0) begin
              state_q <= DIV_BYZERO;
            end else begin
              state_q <= DIV_ON;
            end
          end
        end

        DIV_BYZERO: begin
          result_q <= '0;
          ready_q  <= DIV_RESULT_NOT_READY;
          if (bus.annul_i) begin
            state_q <= DIV_FREE;
          end else begin
            state_q <= DIV_END;
          end
        end

        DIV_ON: begin
          if (bus.annul_i) begin
            state_q  <= DIV_FREE;
            ready_q  <= DIV_RESULT_NOT_READY;
            result_q <= '0;
          end else if (cnt_q != CNT_W'(DATA_W)) begin
            rem_q <= rem_step_d;
            quo_q <= quo_step_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            state_q  <= DIV_END;
            ready_q  <= DIV_RESULT_READY;
            result_q <= {rem_fix_d, quo_fix_d};
          end
        end

        DIV_END: begin
          if (bus.start_i == DIV_STOP || bus.annul_i) begin
            state_q  <= DIV_FREE;
            ready_q  <= DIV_RESULT_NOT_READY;
            result_q <= '0;
          end else begin
            // The divide-by-zero path arrives here with ready low and a zero
            // result; the normal path arrives already ready. Either way the
            // result is held from here on.
            ready_q <= DIV_RESULT_READY;
          end
        end

        default: begin
          state_q  <= DIV_FREE;
          ready_q  <= DIV_RESULT_NOT_READY;
          result_q <= '0;
        end
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_div.sv
// -----------------------------------------------------------------------------
// tb_div
// Directed bench for the DIV/DIVU unit. A behavioural model (plain integer
// division) supplies the expected {remainder, quotient}; a compare process
// checks ready_o/result_o every cycle against the expected queue.
// -----------------------------------------------------------------------------
module tb_div;
  import div_pkg::*;

  localparam int W = 32;

  logic       clk;
  logic       rst;
  div_state_e state;

  div_if #(.DATA_W(W)) bus ();

  div #(.DATA_W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string name, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: MIPS DIV/DIVU semantics using 64-bit integer math
  // (truncating division, remainder takes the dividend's sign).
  function automatic logic [2*W-1:0] model_div(input logic sgn,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    longint x, y, q, r;
    logic [2*W-1:0] qq, rr;
    if (b == '0) return '0;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q  = x / y;
    r  = x % y;
    qq = q;
    rr = r;
    return {rr[W-1:0], qq[W-1:0]};
  endfunction

  // Per-cycle compare: while ready_o is high the result must match the
  // oldest outstanding expectation; otherwise result_o must be zero.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ready_o) begin
        if (exp_q.size() == 0) check("unexpected_ready", {63'd0, bus.ready_o}, '0);
        else                   check("result", bus.result_o, exp_q[0]);
      end else begin
        check("idle_result", bus.result_o, '0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input string name, input logic sgn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] lit, input int exp_lat);
    int  cycles;
    bit  got;
    check({"model_", name}, model_div(sgn, a, b), lit);
    exp_q.push_back(model_div(sgn, a, b));
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    @(posedge clk);            // edge T: request accepted
    #1;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 100) begin
      tick();
      cycles++;
      if (bus.ready_o) got = 1'b1;
    end
    check({"latency_", name}, 64'(cycles), 64'(exp_lat));
    check({"lit_", name}, bus.result_o, lit);
    // Operand changes after capture must not disturb the held result.
    bus.opdata1_i = 32'hDEAD_BEEF;
    bus.opdata2_i = 32'h0000_0003;
    repeat (2) begin
      tick();
      check({"hold_ready_", name}, {63'd0, bus.ready_o}, 64'd1);
    end
    bus.start_i = 1'b0;
    tick();
    check({"drop_ready_", name}, {63'd0, bus.ready_o}, 64'd0);
    check({"drop_state_", name}, {62'd0, state}, {62'd0, DIV_FREE});
    void'(exp_q.pop_front());
    tick();
  endtask

  typedef struct {
    string          name;
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] lit;
    int             lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"divu_7_2",     1'b0, 32'd7,          32'd2,          {32'h1,        32'h3},        33};
    vecs[1] = '{"div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,32'hFFFF_FFFD},33};
    vecs[2] = '{"div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h1,        32'hFFFF_FFFD},33};
    vecs[3] = '{"divu_by0",     1'b0, 32'h1234_5678,  32'd0,          64'd0,                        2};
    vecs[4] = '{"div_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0,        32'h8000_0000},33};
    vecs[5] = '{"divu_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0,        32'hFFFF_FFFF},33};
    vecs[6] = '{"div_m100_7",   1'b1, 32'hFFFF_FF9C,  32'd7,          {32'hFFFF_FFFE,32'hFFFF_FFF2},33};
    vecs[7] = '{"div_min_2",    1'b1, 32'h8000_0000,  32'd2,          {32'h0,        32'hC000_0000},33};
    vecs[8] = '{"divu_5_10",    1'b0, 32'd5,          32'd10,         {32'h5,        32'h0},        33};
    vecs[9] = '{"div_m5_m10",   1'b1, 32'hFFFF_FFFB,  32'hFFFF_FFF6,  {32'hFFFF_FFFB,32'h0},        33};
  end

  // Absolute time bound.
  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) tick();
    check("rst_ready",  {63'd0, bus.ready_o}, 64'd0);
    check("rst_result", bus.result_o, 64'd0);
    check("rst_state",  {62'd0, state}, {62'd0, DIV_FREE});
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++)
      run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lit, vecs[i].lat);

    // Annul during ON at T+10; ready must never rise, then a fresh
    // DIVU 100/7 is started on the following cycle.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'h0001_0000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    @(posedge clk);            // edge T
    #1;
    check("annul_on_state", {62'd0, state}, {62'd0, DIV_ON});
    repeat (9) tick();
    bus.annul_i = 1'b1;
    tick();                    // edge T+10
    check("annul_state", {62'd0, state}, {62'd0, DIV_FREE});
    check("annul_ready", {63'd0, bus.ready_o}, 64'd0);
    bus.annul_i = 1'b0;
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

    // Annul while in BYZERO.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd9;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b1;
    tick();
    check("byzero_state", {62'd0, state}, {62'd0, DIV_BYZERO});
    bus.annul_i = 1'b1;
    tick();
    check("byzero_annul_state", {62'd0, state}, {62'd0, DIV_FREE});
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    repeat (4) tick();

    // Reset at T+20 mid-division.
    bus.opdata1_i = 32'h1234_5678;
    bus.opdata2_i = 32'h0000_0011;
    bus.start_i   = 1'b1;
    @(posedge clk);            // edge T
    #1;
    repeat (19) tick();
    rst = 1'b1;
    tick();                    // edge T+20
    check("midrst_ready",  {63'd0, bus.ready_o}, 64'd0);
    check("midrst_result", bus.result_o, 64'd0);
    check("midrst_state",  {62'd0, state}, {62'd0, DIV_FREE});
    rst         = 1'b0;
    bus.start_i = 1'b0;
    repeat (40) tick();

    // start and annul together in FREE: nothing starts.
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("start_annul_state", {62'd0, state}, {62'd0, DIV_FREE});
    end
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    repeat (40) tick();

    // The unit still works afterwards.
    run_div("div_50_m5", 1'b1, 32'd50, 32'hFFFF_FFFB, {32'h0, 32'hFFFF_FFF6}, 33);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
